fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, drives the address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It also handles load-use stalls and taken-branch redirects from the hazard unit and ID/EX logic, and traps fetches outside the instruction memory. The decode stage consumes its IF/ID outputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal byte addresses are 0 .. IMEM_WORDS*4-4.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit load-use stall; hold PC and IF/ID.
- redirect  in  1  taken branch/jump resolved downstream; flush IF/ID.
- redirect_target  in  32  byte address to fetch next when redirect=1.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_rdata  in  32  instruction word, valid combinationally in the same cycle as imem_addr.
- ifid_instr  out  32  instruction to decode; NOP (32'h0) when invalid.
- ifid_pc_plus4  out  32  address of the latched instruction + 4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky fetch fault; high until reset.
- fault_addr  out  32  offending address captured at fault entry.
- fetch_count  out  32  number of valid instructions latched into IF/ID; wraps modulo 2^32.

## Operation
- State machine with two states, RUN and FAULT. Reset enters RUN.
- Event priority in RUN, evaluated each rising edge: redirect > stall > advance.
- Redirect, target aligned and in range:
  - pc <= redirect_target.
  - IF/ID <= bubble (instr 0, pc_plus4 0, valid 0).
  - Redirect wins over a simultaneous stall.
- Redirect, target misaligned (target[1:0]≠0) or ≥ IMEM_WORDS*4:
  - Go to FAULT; fault_addr <= target; pc <= target; IF/ID <= bubble.
- Stall without redirect: pc, IF/ID and fetch_count all hold.
- Advance, pc in range:
  - pc <= pc+4.
  - IF/ID <= {imem_rdata, pc+4, valid 1}.
  - fetch_count increments by 1.
- Advance, pc ≥ IMEM_WORDS*4: go to FAULT; fault_addr <= pc; IF/ID <= bubble.
- FAULT:
  - pc, fault_addr and fetch_count are frozen.
  - IF/ID holds the bubble.
  - stall and redirect are ignored.
  - fault=1.
  - Only reset exits FAULT.
- All arithmetic is 32-bit unsigned with wrap. pc+4 overflow is not special-cased; the range check catches it.

## Timing
- Reset values, applied asynchronously:
  - imem_addr=RESET_PC; ifid_instr=0; ifid_pc_plus4=0; ifid_valid=0.
  - fault=0; fault_addr=0; fetch_count=0; state=RUN.
- Fetch latency: the word at address A appears on IF/ID one edge after imem_addr=A.
- Redirect asserted in cycle N:
  - imem_addr=target in N+1, and IF/ID holds a bubble in N+1.
  - The target instruction is in IF/ID in N+2.
- Stall asserted in cycle N: outputs in N+1 equal those in N. A stall held K cycles holds for K cycles.
- Reset asserted mid-operation clears everything immediately. The first fetch from RESET_PC latches on the first edge after reset deasserts.
- All outputs come directly from flops; there is no combinational path from input to output.

## Structure
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0000_0000.
  - fetch_state_t enum {RUN, FAULT}.
  - Default RESET_PC and IMEM_WORDS.
- Sub-module ifid_reg: a 32+32+1 pipeline register with hold (stall) and clear (flush) controls, with clear taking priority. It is reused style-wise by the later ID/EX register.
- The top level contains the PC register, the next-PC mux, the range/alignment check, the FSM and the counter.

## Test plan
- Reset and straight-line fetch:
  - Stimulus: imem returns 32'h01095020, AC0A0000, 01495822 at 0/4/8.
  - Expected: after 3 edges IF/ID shows instr 01495822, pc_plus4 12, valid 1, fetch_count 3, imem_addr 12.
- Stall for 2 cycles at imem_addr 8: all outputs unchanged for exactly 2 edges, then advance to imem_addr 12.
- Branch redirect (beq at 12, target 0):
  - Stimulus: redirect=1 with target 0 asserted together with stall=1.
  - Expected: next cycle imem_addr 0, ifid_valid 0, fetch_count unchanged.
  - Expected: the following cycle IF/ID holds 01095020 with pc_plus4 4.
- Misaligned redirect target 32'h6: fault=1, fault_addr 6, ifid_valid 0. Subsequent redirects and stalls are ignored.
- Run off the end with IMEM_WORDS=4:
  - Expected: after 4 valid fetches, the edge at pc 16 sets fault with fault_addr 16 and fetch_count 4.
- Asynchronous reset pulse between edges while in FAULT:
  - Expected: immediate return to all reset values.
  - Expected: the first edge after reset release latches the word at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
//   NOP_INSTR          - encoding placed in pipeline registers for a bubble
//   fetch_state_t      - fetch-stage FSM states
//   DEFAULT_RESET_PC   - default PC after reset
//   DEFAULT_IMEM_WORDS - default instruction memory depth in 32-bit words
package mips_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_WORDS = 1024;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, pc+4 and valid bit.
//   clk, reset            - clock, asynchronous active-high reset
//   hold                  - keep current contents (stall)
//   clear                 - load a bubble (flush); wins over hold
//   instr_d, pc_plus4_d,
//   valid_d               - next contents when neither hold nor clear
//   instr, pc_plus4, valid - registered outputs
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        clear,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_plus4_d,
    input  logic        valid_d,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (clear) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (!hold) begin
            instr    <= instr_d;
            pc_plus4 <= pc_plus4_d;
            valid    <= valid_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch range and
// alignment trap, IF/ID register and valid-fetch counter.
//   clk, reset       - clock, asynchronous active-high reset
//   stall            - hold PC, IF/ID and counter
//   redirect,
//   redirect_target  - taken branch/jump; flush IF/ID and fetch from target
//   imem_addr        - byte address to the combinational instruction memory
//   imem_rdata       - instruction word at imem_addr, same cycle
//   ifid_instr, ifid_pc_plus4, ifid_valid - IF/ID register outputs
//   fault, fault_addr - sticky fetch trap and offending byte address
//   fetch_count      - valid instructions latched into IF/ID, wrapping
//
// State table
//   state | meaning
//   RUN   | fetching normally; redirect > stall > advance
//   FAULT | trapped on a bad fetch address; everything frozen until reset
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4;
    logic [31:0]  fault_addr_next, count_next;
    logic         ifid_hold, ifid_clear;
    logic         target_ok, pc_in_range;

    assign pc_plus4    = pc + 32'd4;
    // An overflowed pc+4 wraps to a small value but the pc itself is then
    // already out of range, so this single compare covers the wrap case.
    assign pc_in_range = (pc < IMEM_BYTES);
    assign target_ok   = (redirect_target[1:0] == 2'b00) && (redirect_target < IMEM_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fault_addr  <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fault_addr  <= fault_addr_next;
            fetch_count <= count_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        fault_addr_next = fault_addr;
        count_next      = fetch_count;
        ifid_hold       = 1'b0;
        ifid_clear      = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    pc_next    = redirect_target;
                    if (!target_ok) begin
                        state_next      = FAULT;
                        fault_addr_next = redirect_target;
                    end
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (pc_in_range) begin
                    pc_next    = pc_plus4;
                    count_next = fetch_count + 32'd1;
                end else begin
                    ifid_clear      = 1'b1;
                    state_next      = FAULT;
                    fault_addr_next = pc;
                end
            end
            FAULT: begin
                ifid_clear = 1'b1;
            end
            default: begin
                ifid_clear = 1'b1;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .hold       (ifid_hold),
        .clear      (ifid_clear),
        .instr_d    (imem_rdata),
        .pc_plus4_d (pc_plus4),
        .valid_d    (1'b1),
        .instr      (ifid_instr),
        .pc_plus4   (ifid_pc_plus4),
        .valid      (ifid_valid)
    );

    assign imem_addr = pc;
    assign fault     = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset, rst_s;
    logic        stall, redirect;
    logic [31:0] redirect_target;

    logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc_plus4;
    logic        ifid_valid, fault;
    logic [31:0] fault_addr, fetch_count;

    logic [31:0] s_imem_addr, s_imem_rdata, s_ifid_instr, s_ifid_pc_plus4;
    logic        s_ifid_valid, s_fault;
    logic [31:0] s_fault_addr, s_fetch_count;

    logic [31:0] mem [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ifid_instr(ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .fault(fault), .fault_addr(fault_addr), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
        .clk(clk), .reset(rst_s), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(s_imem_addr),
        .imem_rdata(s_imem_rdata), .ifid_instr(s_ifid_instr),
        .ifid_pc_plus4(s_ifid_pc_plus4), .ifid_valid(s_ifid_valid),
        .fault(s_fault), .fault_addr(s_fault_addr), .fetch_count(s_fetch_count)
    );

    assign imem_rdata   = (imem_addr   < 32'd4096) ? mem[imem_addr[11:2]]   : 32'hDEAD_BEEF;
    assign s_imem_rdata = (s_imem_addr < 32'd4096) ? mem[s_imem_addr[11:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        if (imem_addr !== 32'h0)     begin $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); n_fail++; end n_cmp++;
        if (ifid_instr !== 32'h0)    begin $display("FAIL rst_instr got=%h exp=%h", ifid_instr, 32'h0); n_fail++; end n_cmp++;
        if (ifid_pc_plus4 !== 32'h0) begin $display("FAIL rst_pc4 got=%h exp=%h", ifid_pc_plus4, 32'h0); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b0)     begin $display("FAIL rst_valid got=%b exp=0", ifid_valid); n_fail++; end n_cmp++;
        if (fault !== 1'b0)          begin $display("FAIL rst_fault got=%b exp=0", fault); n_fail++; end n_cmp++;
        if (fault_addr !== 32'h0)    begin $display("FAIL rst_faddr got=%h exp=0", fault_addr); n_fail++; end n_cmp++;
        if (fetch_count !== 32'h0)   begin $display("FAIL rst_count got=%0d exp=0", fetch_count); n_fail++; end n_cmp++;
        step();
        step();
        if (imem_addr !== 32'h0)     begin $display("FAIL rst_held_addr got=%h exp=0", imem_addr); n_fail++; end n_cmp++;
        reset = 1'b0;
    endtask

    task automatic test_straight_and_stall();
        step();
        if (ifid_instr !== 32'h0109_5020)  begin $display("FAIL e1_instr got=%h exp=01095020", ifid_instr); n_fail++; end n_cmp++;
        if (ifid_pc_plus4 !== 32'd4)       begin $display("FAIL e1_pc4 got=%0d exp=4", ifid_pc_plus4); n_fail++; end n_cmp++;
        if (imem_addr !== 32'd4)           begin $display("FAIL e1_addr got=%0d exp=4", imem_addr); n_fail++; end n_cmp++;
        step();
        if (ifid_instr !== 32'hAC0A_0000)  begin $display("FAIL e2_instr got=%h exp=ac0a0000", ifid_instr); n_fail++; end n_cmp++;
        if (imem_addr !== 32'd8)           begin $display("FAIL e2_addr got=%0d exp=8", imem_addr); n_fail++; end n_cmp++;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            if (imem_addr !== 32'd8)          begin $display("FAIL stall_addr[%0d] got=%0d exp=8", k, imem_addr); n_fail++; end n_cmp++;
            if (ifid_instr !== 32'hAC0A_0000) begin $display("FAIL stall_instr[%0d] got=%h exp=ac0a0000", k, ifid_instr); n_fail++; end n_cmp++;
            if (ifid_pc_plus4 !== 32'd8)      begin $display("FAIL stall_pc4[%0d] got=%0d exp=8", k, ifid_pc_plus4); n_fail++; end n_cmp++;
            if (ifid_valid !== 1'b1)          begin $display("FAIL stall_valid[%0d] got=%b exp=1", k, ifid_valid); n_fail++; end n_cmp++;
            if (fetch_count !== 32'd2)        begin $display("FAIL stall_count[%0d] got=%0d exp=2", k, fetch_count); n_fail++; end n_cmp++;
        end
        stall = 1'b0;
        step();
        if (ifid_instr !== 32'h0149_5822) begin $display("FAIL e3_instr got=%h exp=01495822", ifid_instr); n_fail++; end n_cmp++;
        if (ifid_pc_plus4 !== 32'd12)     begin $display("FAIL e3_pc4 got=%0d exp=12", ifid_pc_plus4); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b1)          begin $display("FAIL e3_valid got=%b exp=1", ifid_valid); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd3)        begin $display("FAIL e3_count got=%0d exp=3", fetch_count); n_fail++; end n_cmp++;
        if (imem_addr !== 32'd12)         begin $display("FAIL e3_addr got=%0d exp=12", imem_addr); n_fail++; end n_cmp++;
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_target = 32'd0; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        if (imem_addr !== 32'd0)    begin $display("FAIL br_addr got=%0d exp=0", imem_addr); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b0)    begin $display("FAIL br_valid got=%b exp=0", ifid_valid); n_fail++; end n_cmp++;
        if (ifid_instr !== 32'h0)   begin $display("FAIL br_instr got=%h exp=0", ifid_instr); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd3)  begin $display("FAIL br_count got=%0d exp=3", fetch_count); n_fail++; end n_cmp++;
        step();
        if (ifid_instr !== 32'h0109_5020) begin $display("FAIL br2_instr got=%h exp=01095020", ifid_instr); n_fail++; end n_cmp++;
        if (ifid_pc_plus4 !== 32'd4)      begin $display("FAIL br2_pc4 got=%0d exp=4", ifid_pc_plus4); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b1)          begin $display("FAIL br2_valid got=%b exp=1", ifid_valid); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd4)        begin $display("FAIL br2_count got=%0d exp=4", fetch_count); n_fail++; end n_cmp++;
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_target = 32'h6;
        step();
        if (fault !== 1'b1)         begin $display("FAIL mis_fault got=%b exp=1", fault); n_fail++; end n_cmp++;
        if (fault_addr !== 32'h6)   begin $display("FAIL mis_faddr got=%h exp=6", fault_addr); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b0)    begin $display("FAIL mis_valid got=%b exp=0", ifid_valid); n_fail++; end n_cmp++;
        if (imem_addr !== 32'h6)    begin $display("FAIL mis_addr got=%h exp=6", imem_addr); n_fail++; end n_cmp++;
        redirect_target = 32'h0; stall = 1'b1;
        step();
        redirect = 1'b0;
        step();
        stall = 1'b0;
        step();
        if (fault !== 1'b1)         begin $display("FAIL mis_sticky got=%b exp=1", fault); n_fail++; end n_cmp++;
        if (imem_addr !== 32'h6)    begin $display("FAIL mis_frozen_addr got=%h exp=6", imem_addr); n_fail++; end n_cmp++;
        if (fault_addr !== 32'h6)   begin $display("FAIL mis_frozen_faddr got=%h exp=6", fault_addr); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd4)  begin $display("FAIL mis_frozen_count got=%0d exp=4", fetch_count); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b0)    begin $display("FAIL mis_bubble got=%b exp=0", ifid_valid); n_fail++; end n_cmp++;
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        if (fault !== 1'b0)         begin $display("FAIL ar_fault got=%b exp=0", fault); n_fail++; end n_cmp++;
        if (imem_addr !== 32'h0)    begin $display("FAIL ar_addr got=%h exp=0", imem_addr); n_fail++; end n_cmp++;
        if (fault_addr !== 32'h0)   begin $display("FAIL ar_faddr got=%h exp=0", fault_addr); n_fail++; end n_cmp++;
        if (fetch_count !== 32'h0)  begin $display("FAIL ar_count got=%0d exp=0", fetch_count); n_fail++; end n_cmp++;
        #1;
        reset = 1'b0;
        step();
        if (ifid_instr !== 32'h0109_5020) begin $display("FAIL ar1_instr got=%h exp=01095020", ifid_instr); n_fail++; end n_cmp++;
        if (ifid_pc_plus4 !== 32'd4)      begin $display("FAIL ar1_pc4 got=%0d exp=4", ifid_pc_plus4); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd1)        begin $display("FAIL ar1_count got=%0d exp=1", fetch_count); n_fail++; end n_cmp++;
    endtask

    task automatic test_last_word();
        redirect = 1'b1; redirect_target = 32'd4092;
        step();
        redirect = 1'b0;
        if (fault !== 1'b0)         begin $display("FAIL lw_fault got=%b exp=0", fault); n_fail++; end n_cmp++;
        if (imem_addr !== 32'd4092) begin $display("FAIL lw_addr got=%0d exp=4092", imem_addr); n_fail++; end n_cmp++;
        step();
        if (ifid_instr !== 32'h3C01_1234) begin $display("FAIL lw_instr got=%h exp=3c011234", ifid_instr); n_fail++; end n_cmp++;
        if (ifid_pc_plus4 !== 32'd4096)   begin $display("FAIL lw_pc4 got=%0d exp=4096", ifid_pc_plus4); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd2)        begin $display("FAIL lw_count got=%0d exp=2", fetch_count); n_fail++; end n_cmp++;
        step();
        if (fault !== 1'b1)          begin $display("FAIL end_fault got=%b exp=1", fault); n_fail++; end n_cmp++;
        if (fault_addr !== 32'd4096) begin $display("FAIL end_faddr got=%0d exp=4096", fault_addr); n_fail++; end n_cmp++;
        if (fetch_count !== 32'd2)   begin $display("FAIL end_count got=%0d exp=2", fetch_count); n_fail++; end n_cmp++;
        if (ifid_valid !== 1'b0)     begin $display("FAIL end_valid got=%b exp=0", ifid_valid); n_fail++; end n_cmp++;
    endtask

    task automatic test_small_run_off();
        stall = 1'b0; redirect = 1'b0;
        rst_s = 1'b0;
        for (int k = 0; k < 4; k++) step();
        if (s_fetch_count !== 32'd4)       begin $display("FAIL sm_count got=%0d exp=4", s_fetch_count); n_fail++; end n_cmp++;
        if (s_ifid_instr !== 32'h1000_FFFC) begin $display("FAIL sm_instr got=%h exp=1000fffc", s_ifid_instr); n_fail++; end n_cmp++;
        if (s_imem_addr !== 32'd16)        begin $display("FAIL sm_addr got=%0d exp=16", s_imem_addr); n_fail++; end n_cmp++;
        if (s_fault !== 1'b0)              begin $display("FAIL sm_prefault got=%b exp=0", s_fault); n_fail++; end n_cmp++;
        step();
        if (s_fault !== 1'b1)              begin $display("FAIL sm_fault got=%b exp=1", s_fault); n_fail++; end n_cmp++;
        if (s_fault_addr !== 32'd16)       begin $display("FAIL sm_faddr got=%0d exp=16", s_fault_addr); n_fail++; end n_cmp++;
        if (s_fetch_count !== 32'd4)       begin $display("FAIL sm_count2 got=%0d exp=4", s_fetch_count); n_fail++; end n_cmp++;
        if (s_ifid_valid !== 1'b0)         begin $display("FAIL sm_valid got=%b exp=0", s_ifid_valid); n_fail++; end n_cmp++;
        if (s_imem_addr !== 32'd16)        begin $display("FAIL sm_frozen got=%0d exp=16", s_imem_addr); n_fail++; end n_cmp++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);
        mem[0]    = 32'h0109_5020;
        mem[1]    = 32'hAC0A_0000;
        mem[2]    = 32'h0149_5822;
        mem[3]    = 32'h1000_FFFC;
        mem[1023] = 32'h3C01_1234;
        reset = 1'b0; rst_s = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        #1;
        reset = 1'b1; rst_s = 1'b1;
        test_reset();
        test_straight_and_stall();
        test_redirect();
        test_misaligned();
        test_async_reset();
        test_last_word();
        test_small_run_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
